// File: rtl/analog_anneal_ctrl.sv
// Run sequencer for the analog Ising macro wrapper: configure, optional J/h load,
// then iterate spin push/collect until the iteration limit or convergence.
module analog_anneal_ctrl #(
    parameter int unsigned NUM_SPIN        = 256,
    parameter int unsigned ITER_BITWIDTH   = 16,
    parameter int unsigned STABLE_BITWIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       skip_load_i,
    input  logic [ITER_BITWIDTH-1:0]   iter_num_i,
    input  logic [STABLE_BITWIDTH-1:0] stable_thresh_i,
    input  logic [NUM_SPIN-1:0]        init_spin_i,
    output logic                       analog_cfg_en_o,
    output logic                       dt_cfg_enable_o,
    input  logic                       dt_cfg_idle_i,
    output logic                       spin_pop_valid_o,
    input  logic                       spin_pop_ready_i,
    output logic [NUM_SPIN-1:0]        spin_pop_o,
    input  logic                       spin_valid_i,
    output logic                       spin_ready_o,
    input  logic [NUM_SPIN-1:0]        spin_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [NUM_SPIN-1:0]        result_spin_o,
    output logic [ITER_BITWIDTH-1:0]   iter_count_o,
    output logic                       converged_o,
    output logic                       busy_o,
    output logic                       done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LOAD, S_LOAD_BUSY, S_LOAD_DONE, S_PUSH, S_WAIT_SPIN, S_OUT
    } state_e;

    state_e                     state_q, state_d;
    logic [ITER_BITWIDTH-1:0]   iter_num_q, iter_num_d;
    logic [STABLE_BITWIDTH-1:0] thresh_q, thresh_d;
    logic                       skip_load_q, skip_load_d;
    logic [NUM_SPIN-1:0]        spin_q, spin_d;
    logic [STABLE_BITWIDTH-1:0] stable_q, stable_d;
    logic [ITER_BITWIDTH-1:0]   iter_count_q, iter_count_d;
    logic                       converged_q, converged_d;

    logic [STABLE_BITWIDTH-1:0] stable_sat;
    logic [STABLE_BITWIDTH-1:0] stable_new;
    logic [ITER_BITWIDTH-1:0]   iter_new;
    logic                       conv_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            iter_num_q   <= '0;
            thresh_q     <= '0;
            skip_load_q  <= 1'b0;
            spin_q       <= '0;
            stable_q     <= '0;
            iter_count_q <= '0;
            converged_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_num_q   <= iter_num_d;
            thresh_q     <= thresh_d;
            skip_load_q  <= skip_load_d;
            spin_q       <= spin_d;
            stable_q     <= stable_d;
            iter_count_q <= iter_count_d;
            converged_q  <= converged_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        iter_num_d   = iter_num_q;
        thresh_d     = thresh_q;
        skip_load_d  = skip_load_q;
        spin_d       = spin_q;
        stable_d     = stable_q;
        iter_count_d = iter_count_q;
        converged_d  = converged_q;

        stable_sat = (stable_q == '1) ? stable_q : stable_q + 1'b1;
        stable_new = (spin_i == spin_q) ? stable_sat : '0;
        iter_new   = iter_count_q + 1'b1;
        conv_hit   = (thresh_q != '0) && (stable_new >= thresh_q);

        // Abort wins over every transition and freezes the run bookkeeping.
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        iter_num_d   = iter_num_i;
                        thresh_d     = stable_thresh_i;
                        skip_load_d  = skip_load_i;
                        spin_d       = init_spin_i;
                        stable_d     = '0;
                        iter_count_d = '0;
                        converged_d  = 1'b0;
                        state_d      = S_CFG;
                    end
                end
                S_CFG: begin
                    if (!skip_load_q)           state_d = S_LOAD;
                    else if (iter_num_q == '0)  state_d = S_OUT;
                    else                        state_d = S_PUSH;
                end
                S_LOAD:      state_d = S_LOAD_BUSY;
                // Idle may still read high right after the pulse; wait for it to drop first.
                S_LOAD_BUSY: if (!dt_cfg_idle_i) state_d = S_LOAD_DONE;
                S_LOAD_DONE: begin
                    if (dt_cfg_idle_i) state_d = (iter_num_q == '0) ? S_OUT : S_PUSH;
                end
                S_PUSH:      if (spin_pop_ready_i) state_d = S_WAIT_SPIN;
                S_WAIT_SPIN: begin
                    if (spin_valid_i) begin
                        iter_count_d = iter_new;
                        stable_d     = stable_new;
                        spin_d       = spin_i;
                        if (conv_hit) begin
                            converged_d = 1'b1;
                            state_d     = S_OUT;
                        end else if (iter_new == iter_num_q) begin
                            state_d = S_OUT;
                        end else begin
                            state_d = S_PUSH;
                        end
                    end
                end
                S_OUT:       if (result_ready_i) state_d = S_IDLE;
                default:     state_d = S_IDLE;
            endcase
        end
    end

    assign analog_cfg_en_o  = (state_q == S_CFG);
    assign dt_cfg_enable_o  = (state_q == S_LOAD);
    assign spin_pop_valid_o = (state_q == S_PUSH);
    assign spin_pop_o       = spin_q;
    assign spin_ready_o     = (state_q == S_WAIT_SPIN);
    assign result_valid_o   = (state_q == S_OUT);
    assign result_spin_o    = spin_q;
    assign iter_count_o     = iter_count_q;
    assign converged_o      = converged_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = (state_q == S_OUT) && result_ready_i && !abort_i;

endmodule
